// File: rtl/mpeg_system_stream_demux_if.sv
// Byte-stream interface between a system-stream source and the demux:
// system bytes in, selected video elementary bytes plus timestamps and events out.
interface mpeg_system_stream_demux_if;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic [3:0]  video_stream_sel;
    logic [7:0]  video_data;
    logic        video_data_valid;
    logic [32:0] scr;
    logic        event_pack;
    logic [32:0] pts;
    logic        pts_valid;
    logic        event_end_code;
    logic        packet_error;

    modport master (
        output data_in, data_in_valid, video_stream_sel,
        input  video_data, video_data_valid, scr, event_pack,
               pts, pts_valid, event_end_code, packet_error
    );

    modport slave (
        input  data_in, data_in_valid, video_stream_sel,
        output video_data, video_data_valid, scr, event_pack,
               pts, pts_valid, event_end_code, packet_error
    );
endinterface

// File: rtl/mpeg_system_stream_demux.sv
// MPEG-1 system stream demux: parses pack/system/PES headers byte by byte,
// forwards the selected video PES payload and extracts SCR and PTS.
module mpeg_system_stream_demux #(
    parameter int MAX_STUFFING = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    mpeg_system_stream_demux_if.slave     bus
);
    localparam int SW = $clog2(MAX_STUFFING + 2);
    localparam logic [SW-1:0] STUFF_MAX = SW'(MAX_STUFFING);

    typedef enum logic [3:0] {
        S_IDLE, S_Z1, S_Z2, S_ID, S_PACK, S_LEN_HI, S_LEN_LO,
        S_SKIP, S_HDR, S_STD, S_PTS, S_PAYLOAD
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_rem, w_rem_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [SW-1:0]   r_stuff, w_stuff_nxt;
    logic            r_video, w_video_nxt;
    logic            r_dts, w_dts_nxt;
    logic [32:0]     r_ts, w_ts_nxt;

    logic [7:0]      w_byte;
    logic            w_vld, w_last, w_pts_done;
    logic            w_ev_pack, w_ev_pts, w_ev_end, w_ev_err, w_ev_vid;

    logic [7:0]      r_video_data;
    logic            r_video_valid, r_pack, r_pts_valid, r_end, r_err;
    logic [32:0]     r_scr, r_pts;

    // SCR and PTS share the same 5-byte bit packing with interleaved marker bits.
    function automatic logic [32:0] ts_insert(input logic [32:0] ts,
                                              input logic [3:0]  idx,
                                              input logic [7:0]  b);
        logic [32:0] t;
        t = ts;
        case (idx)
            4'd0:    t[32:30] = b[3:1];
            4'd1:    t[29:22] = b;
            4'd2:    t[21:15] = b[7:1];
            4'd3:    t[14:7]  = b;
            4'd4:    t[6:0]   = b[7:1];
            default: t = ts;
        endcase
        return t;
    endfunction

    assign w_byte     = bus.data_in;
    assign w_vld      = bus.data_in_valid;
    assign w_last     = (r_rem == 16'd1);
    assign w_pts_done = r_dts ? (r_cnt == 4'd9) : (r_cnt == 4'd4);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_stuff <= '0;
            r_video <= 1'b0;
            r_dts   <= 1'b0;
            r_ts    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stuff <= w_stuff_nxt;
            r_video <= w_video_nxt;
            r_dts   <= w_dts_nxt;
            r_ts    <= w_ts_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        w_stuff_nxt = r_stuff;
        w_video_nxt = r_video;
        w_dts_nxt   = r_dts;
        w_ts_nxt    = r_ts;
        if (w_vld) begin
            // Every byte past the length field counts against the packet length.
            if (r_state inside {S_SKIP, S_HDR, S_STD, S_PTS, S_PAYLOAD})
                w_rem_nxt = r_rem - 16'd1;
            case (r_state)
                S_IDLE: if (w_byte == 8'h00) w_state_nxt = S_Z1;
                S_Z1:   w_state_nxt = (w_byte == 8'h00) ? S_Z2 : S_IDLE;
                S_Z2: begin
                    if (w_byte == 8'h01)      w_state_nxt = S_ID;
                    else if (w_byte != 8'h00) w_state_nxt = S_IDLE;
                end
                S_ID: begin
                    w_state_nxt = S_IDLE;
                    if (w_byte == 8'hBA) begin
                        w_state_nxt = S_PACK;
                        w_cnt_nxt   = '0;
                    end else if (w_byte >= 8'hBB) begin
                        w_state_nxt = S_LEN_HI;
                        w_video_nxt = (w_byte == {4'hE, bus.video_stream_sel});
                    end
                end
                S_PACK: begin
                    w_ts_nxt  = ts_insert(r_ts, r_cnt, w_byte);
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_LEN_HI: begin
                    w_rem_nxt   = {w_byte, r_rem[7:0]};
                    w_state_nxt = S_LEN_LO;
                end
                S_LEN_LO: begin
                    w_rem_nxt   = {r_rem[15:8], w_byte};
                    w_stuff_nxt = '0;
                    if ({r_rem[15:8], w_byte} == 16'd0) w_state_nxt = S_IDLE;
                    else w_state_nxt = r_video ? S_HDR : S_SKIP;
                end
                S_HDR: begin
                    if (w_byte == 8'hFF) begin
                        w_stuff_nxt = r_stuff + SW'(1);
                        if (r_stuff >= STUFF_MAX) w_state_nxt = S_SKIP;
                    end else if (w_byte[7:6] == 2'b01) begin
                        w_state_nxt = S_STD;
                    end else if (w_byte[7:5] == 3'b001) begin
                        w_state_nxt = S_PTS;
                        w_cnt_nxt   = 4'd1;
                        w_dts_nxt   = w_byte[4];
                        w_ts_nxt    = ts_insert(r_ts, 4'd0, w_byte);
                    end else if (w_byte == 8'h0F) begin
                        w_state_nxt = S_PAYLOAD;
                    end else begin
                        w_state_nxt = S_SKIP;
                    end
                    if (w_last) w_state_nxt = S_IDLE;
                end
                S_STD:     w_state_nxt = w_last ? S_IDLE : S_HDR;
                S_PTS: begin
                    w_ts_nxt  = ts_insert(r_ts, r_cnt, w_byte);
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (w_pts_done) begin
                        w_state_nxt = S_PAYLOAD;
                        w_cnt_nxt   = '0;
                    end
                    if (w_last) w_state_nxt = S_IDLE;
                end
                S_SKIP, S_PAYLOAD: if (w_last) w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ev_pack = 1'b0;
        w_ev_pts  = 1'b0;
        w_ev_end  = 1'b0;
        w_ev_err  = 1'b0;
        w_ev_vid  = 1'b0;
        if (w_vld) begin
            case (r_state)
                S_ID:      w_ev_end  = (w_byte == 8'hB9);
                S_PACK:    w_ev_pack = (r_cnt == 4'd7);
                S_PAYLOAD: w_ev_vid  = 1'b1;
                // Running out of length anywhere except after 0x0F is a truncated header.
                S_HDR: begin
                    if (w_byte == 8'hFF)
                        w_ev_err = w_last || (r_stuff >= STUFF_MAX);
                    else if (w_byte[7:6] == 2'b01 || w_byte[7:5] == 3'b001)
                        w_ev_err = w_last;
                    else
                        w_ev_err = (w_byte != 8'h0F);
                end
                S_STD:     w_ev_err = w_last;
                S_PTS: begin
                    w_ev_pts = w_pts_done;
                    w_ev_err = w_last && !w_pts_done;
                end
                default:   w_ev_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_video_data  <= '0;
            r_video_valid <= 1'b0;
            r_scr         <= '0;
            r_pack        <= 1'b0;
            r_pts         <= '0;
            r_pts_valid   <= 1'b0;
            r_end         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_video_valid <= w_ev_vid;
            r_pack        <= w_ev_pack;
            r_pts_valid   <= w_ev_pts;
            r_end         <= w_ev_end;
            r_err         <= w_ev_err;
            if (w_ev_vid)  r_video_data <= w_byte;
            if (w_ev_pack) r_scr        <= w_ts_nxt;
            if (w_ev_pts)  r_pts        <= w_ts_nxt;
        end
    end

    assign bus.video_data       = r_video_data;
    assign bus.video_data_valid = r_video_valid;
    assign bus.scr              = r_scr;
    assign bus.event_pack       = r_pack;
    assign bus.pts              = r_pts;
    assign bus.pts_valid        = r_pts_valid;
    assign bus.event_end_code   = r_end;
    assign bus.packet_error     = r_err;
endmodule
